fpu_normalizer: RTL

- Result-normalisation stage directly downstream of the single-precision add/sub/mul datapath.
- Consumes the raw sign, exponent and 25-bit mantissa (carry at bit 24, hidden bit at bit 23).
- Iteratively shifts left one bit per clock until the hidden bit is set, and handles carry-out, zero, exponent overflow and underflow.
- Emits a packed IEEE 754 word plus status flags over a valid/ready handshake.

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fpu_normalizer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fpu_pkg.sv
// Shared single-precision constants, result field layout and normaliser state encoding.
// Imported by the normaliser and by the add/sub/mul stage that feeds it.
package fpu_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

    // Packed result layout {sign, exp, fraction}
    localparam int RES_W        = 1 + EXP_W + MAN_W;
    localparam int RES_SIGN_BIT = RES_W - 1;
    localparam int RES_EXP_LSB  = MAN_W;
    localparam int RES_FRAC_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_e;

endpackage

// File: rtl/fpu_normalizer.sv
// Iterative result normaliser: one left shift per clock until the hidden bit is set, k+1 cycles latency.
// Single-entry: in_ready only in IDLE; result and flags held in DONE until out_ready.
module fpu_normalizer
    import fpu_pkg::*;
#(
    parameter int EXP_W = fpu_pkg::EXP_W,
    parameter int MAN_W = fpu_pkg::MAN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [EXP_W-1:0]         in_exp,
    input  logic [MAN_W+1:0]         in_mant,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic                     out_zero,
    output logic                     out_ovf,
    output logic                     out_uflow,
    output logic                     busy
);

    localparam int M_W = MAN_W + 2;
    localparam int HID = MAN_W;
    localparam int CRY = MAN_W + 1;
    localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    norm_state_e    state_q, state_d;
    logic [EXP_W:0] exp_q, exp_d;
    logic [M_W-1:0] mant_q, mant_d;
    logic           sign_q, sign_d;
    logic           zero_q, zero_d;
    logic           ovf_q, ovf_d;
    logic           uflow_q, uflow_d;

    logic [EXP_W:0] exp_in, exp_inc, exp_dec;
    logic [M_W-1:0] mant_shl;

    // Extra exponent bit keeps the carry increment from wrapping before the overflow test
    assign exp_in   = {1'b0, in_exp};
    assign exp_inc  = exp_in + EXP_ONE;
    assign exp_dec  = exp_q - EXP_ONE;
    assign mant_shl = mant_q << 1;

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        uflow_d = uflow_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    uflow_d = 1'b0;
                    if (in_mant == '0) begin
                        sign_d  = 1'b0;
                        exp_d   = '0;
                        mant_d  = '0;
                        zero_d  = 1'b1;
                        state_d = DONE;
                    end else if (in_mant[CRY]) begin
                        if (exp_inc >= EXP_MAX) begin
                            exp_d  = EXP_MAX;
                            mant_d = '0;
                            ovf_d  = 1'b1;
                        end else begin
                            exp_d  = exp_inc;
                            mant_d = in_mant >> 1;
                        end
                        state_d = DONE;
                    end else if (in_mant[HID]) begin
                        if (exp_in == EXP_MAX) begin
                            exp_d  = EXP_MAX;
                            mant_d = '0;
                            ovf_d  = 1'b1;
                        end else begin
                            exp_d  = exp_in;
                            mant_d = in_mant;
                        end
                        state_d = DONE;
                    end else begin
                        exp_d   = exp_in;
                        mant_d  = in_mant;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                // No denormals: running out of exponent flushes to signed zero
                if (exp_q <= EXP_ONE) begin
                    exp_d   = '0;
                    mant_d  = '0;
                    uflow_d = 1'b1;
                    state_d = DONE;
                end else begin
                    exp_d  = exp_dec;
                    mant_d = mant_shl;
                    if (mant_shl[HID]) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    uflow_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            exp_q   <= '0;
            mant_q  <= '0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            uflow_q <= uflow_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_result = {sign_q, exp_q[EXP_W-1:0], mant_q[MAN_W-1:0]};
    assign out_zero   = zero_q;
    assign out_ovf    = ovf_q;
    assign out_uflow  = uflow_q;

endmodule
